// File: rtl/bt656_pkg.sv
// Shared definitions for the BT.656 receive path.
// TRS constants, XY field layout, parity check and state enums.
package bt656_pkg;

    localparam logic [7:0] TRS_FF = 8'hFF;
    localparam logic [7:0] TRS_00 = 8'h00;

    localparam int XY_ONE = 7;
    localparam int XY_F   = 6;
    localparam int XY_V   = 5;
    localparam int XY_H   = 4;

    typedef enum logic [1:0] {
        PH_CB,
        PH_Y0,
        PH_CR,
        PH_Y1
    } phase_e;

    typedef enum logic [1:0] {
        DET_SRCH,
        DET_G1,
        DET_G2,
        DET_XY
    } det_state_e;

    // True when the XY word has its marker bit set and consistent protection bits
    function automatic logic xy_ok(input logic [7:0] xy);
        logic       f;
        logic       v;
        logic       h;
        logic [3:0] p;
        f = xy[XY_F];
        v = xy[XY_V];
        h = xy[XY_H];
        p = {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
        return xy[XY_ONE] && (xy[3:0] == p);
    endfunction

endpackage

// File: rtl/bt656_trs_detect.sv
// FF 00 00 XY preamble tracker with XY protection check.
// Results are registered so they line up with the delayed data byte.
module bt656_trs_detect
    import bt656_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    output logic       code_vld,
    output logic       code_err,
    output logic       f,
    output logic       v,
    output logic       h,
    output logic       trs_byte
);

    det_state_e state;
    det_state_e state_nx;
    logic       vld_c;
    logic       err_c;
    logic       trs_c;

    // Detector state register
    always_ff @(posedge clk) begin
        if (rst) state <= DET_SRCH;
        else     state <= state_nx;
    end

    // Preamble sequencing; an FF anywhere in the preamble restarts it
    always_comb begin
        state_nx = DET_SRCH;
        unique case (state)
            DET_SRCH: state_nx = (din == TRS_FF) ? DET_G1 : DET_SRCH;
            DET_G1: begin
                if (din == TRS_FF)      state_nx = DET_G1;
                else if (din == TRS_00) state_nx = DET_G2;
                else                    state_nx = DET_SRCH;
            end
            DET_G2: begin
                if (din == TRS_FF)      state_nx = DET_G1;
                else if (din == TRS_00) state_nx = DET_XY;
                else                    state_nx = DET_SRCH;
            end
            DET_XY:   state_nx = DET_SRCH;
            default:  state_nx = DET_SRCH;
        endcase
    end

    // Classify the current byte: code result and whether it belongs to a TRS
    always_comb begin
        vld_c = 1'b0;
        err_c = 1'b0;
        trs_c = (state != DET_SRCH) || (din == TRS_FF);
        if (state == DET_XY) begin
            vld_c = xy_ok(din);
            err_c = !xy_ok(din);
        end
    end

    // Register the classification alongside the delayed byte
    always_ff @(posedge clk) begin
        if (rst) begin
            code_vld <= 1'b0;
            code_err <= 1'b0;
            f        <= 1'b0;
            v        <= 1'b0;
            h        <= 1'b0;
            trs_byte <= 1'b0;
        end else begin
            code_vld <= vld_c;
            code_err <= err_c;
            f        <= din[XY_F];
            v        <= din[XY_V];
            h        <= din[XY_H];
            trs_byte <= trs_c;
        end
    end

endmodule

// File: rtl/bt656_rx.sv
// BT.656 byte stream to Y/Cb/Cr pixels with line/field tracking.
// Two-stage front end, then one registered decode/output stage.
module bt656_rx
    import bt656_pkg::*;
#(
    parameter int ACTIVE_W = 720,
    parameter int LINE_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        td_data,
    output logic [7:0]        pix_y,
    output logic [7:0]        pix_cb,
    output logic [7:0]        pix_cr,
    output logic              pix_valid,
    output logic [LINE_W-1:0] pix_x,
    output logic [LINE_W-1:0] pix_line,
    output logic              field,
    output logic              vblank,
    output logic              hblank,
    output logic              line_start,
    output logic              frame_start,
    output logic              sync_err
);

    localparam logic [LINE_W-1:0] X_LAST = LINE_W'(ACTIVE_W - 1);
    localparam logic [LINE_W-1:0] ONE    = LINE_W'(1);

    logic [7:0]        d_q;
    logic [7:0]        d2;
    logic              code_vld;
    logic              code_err;
    logic              c_f;
    logic              c_v;
    logic              c_h;
    logic              trs_byte;

    logic              active;
    phase_e            phase;
    logic [LINE_W-1:0] x_cnt;
    logic              full;
    logic              ovr;
    logic              blank_seen;
    logic [7:0]        cb_q;
    logic [7:0]        y0_q;
    logic [7:0]        cr_q;

    logic              data_ok;
    logic              emit;
    logic [7:0]        e_y;
    logic [7:0]        e_cr;

    bt656_trs_detect u_det (
        .clk      (clk),
        .rst      (rst),
        .din      (d_q),
        .code_vld (code_vld),
        .code_err (code_err),
        .f        (c_f),
        .v        (c_v),
        .h        (c_h),
        .trs_byte (trs_byte)
    );

    // Input register and delay matching the detector's registered output
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 8'h00;
            d2  <= 8'h00;
        end else begin
            d_q <= td_data;
            d2  <= d_q;
        end
    end

    // Pixel completion: Cr byte emits the even pixel, Y1 the odd one
    always_comb begin
        data_ok = active && !trs_byte && !code_vld && !code_err;
        emit    = 1'b0;
        e_y     = y0_q;
        e_cr    = d2;
        if (data_ok && !full) begin
            if (phase == PH_CR) begin
                emit = 1'b1;
            end else if (phase == PH_Y1) begin
                emit = 1'b1;
                e_y  = d2;
                e_cr = cr_q;
            end
        end
    end

    // Code handling, byte phase tracking, counters and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            active      <= 1'b0;
            phase       <= PH_CB;
            x_cnt       <= '0;
            full        <= 1'b0;
            ovr         <= 1'b0;
            blank_seen  <= 1'b1;
            cb_q        <= 8'h00;
            y0_q        <= 8'h00;
            cr_q        <= 8'h00;
            pix_y       <= 8'h00;
            pix_cb      <= 8'h00;
            pix_cr      <= 8'h00;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_line    <= '0;
            field       <= 1'b0;
            vblank      <= 1'b1;
            hblank      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            pix_valid   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            if (code_err) begin
                sync_err <= 1'b1;
            end else if (code_vld) begin
                field  <= c_f;
                vblank <= c_v;
                if (c_v) blank_seen <= 1'b1;
                if (c_h) begin
                    hblank <= 1'b1;
                    active <= 1'b0;
                    if (active && !full) sync_err <= 1'b1;
                end else begin
                    hblank <= 1'b0;
                    if (c_v) begin
                        active <= 1'b0;
                    end else begin
                        active     <= 1'b1;
                        phase      <= PH_CB;
                        x_cnt      <= '0;
                        full       <= 1'b0;
                        ovr        <= 1'b0;
                        line_start <= 1'b1;
                        blank_seen <= 1'b0;
                        if (blank_seen) begin
                            pix_line    <= '0;
                            frame_start <= !c_f;
                        end else begin
                            pix_line <= pix_line + ONE;
                        end
                    end
                end
            end else if (data_ok) begin
                if (full) begin
                    if (!ovr) begin
                        ovr      <= 1'b1;
                        sync_err <= 1'b1;
                    end
                end else begin
                    phase <= phase_e'(phase + 2'd1);
                    if (phase == PH_CB) cb_q <= d2;
                    if (phase == PH_Y0) y0_q <= d2;
                    if (phase == PH_CR) cr_q <= d2;
                end
            end
            if (emit) begin
                pix_valid <= 1'b1;
                pix_y     <= e_y;
                pix_cb    <= cb_q;
                pix_cr    <= e_cr;
                pix_x     <= x_cnt;
                x_cnt     <= x_cnt + ONE;
                if (x_cnt == X_LAST) full <= 1'b1;
            end
        end
    end

endmodule

// File: doc/bt656_rx.md
# bt656_rx

Receive-side counterpart to the VGA output path. Decodes the ITU-R BT.656 8-bit 4:2:2 byte stream from the TV decoder (TD_DATA, one byte per TD_CLK) into per-pixel Y/Cb/Cr with active-area coordinates, field/blanking flags and frame/line strobes. It sits between the TD_* pins and the frame-buffer writer.

## Interface
- ACTIVE_W, 720: active pixels per line. A line carries 2*ACTIVE_W bytes between SAV and EAV.
- LINE_W, 10: width of the x and line counters.

Ports:
- clk  in  1  byte clock, TD_CLK domain; one stream byte per cycle
- rst  in  1  synchronous reset, active-high
- td_data  in  8  BT.656 byte stream
- pix_y, pix_cb, pix_cr  out  8 each  pixel components; valid while pix_valid
- pix_valid  out  1  one pixel presented this cycle
- pix_x  out  LINE_W  pixel index in line, 0..ACTIVE_W-1
- pix_line  out  LINE_W  active line index in field
- field  out  1  F bit of last accepted code
- vblank  out  1  V bit of last accepted code
- hblank  out  1  1 from EAV until SAV
- line_start  out  1  1-cycle pulse on each accepted active SAV (V=0)
- frame_start  out  1  1-cycle pulse on the first active SAV of field 0
- sync_err  out  1  1-cycle pulse on a protection error or a line-length error

## Operation
- Timing reference code (TRS) is the sequence FF 00 00 XY. Bits of XY: [7]=1, [6]=F, [5]=V, [4]=H, [3:0]=P3..P0.
- Protection bits: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
- If bit 7 = 0 or the parity is wrong: pulse sync_err and discard the code. No flag or counter changes.
- Detector FSM states: SRCH -> (FF) -> G1 -> (00) -> G2 -> (00) -> XY -> SRCH.
  - Any unexpected byte in G1 or G2 returns to SRCH.
  - An FF received in G1 or G2 goes to G1.
  - The detector runs in every cycle, including active video.
- H=1 (EAV):
  - hblank <= 1.
  - If the line was active and pix_x count < ACTIVE_W, pulse sync_err (short line).
- H=0 (SAV):
  - hblank <= 0; field and vblank are loaded.
  - If V=0, enter ACTIVE with byte phase 0 and x = 0.
- Line counter:
  - The first active SAV after a vblank=1 line sets pix_line = 0.
  - Each later active SAV increments pix_line.
  - frame_start pulses on that first active SAV only when F=0.
- Byte phase cycle in ACTIVE: 0=Cb, 1=Y0, 2=Cr, 3=Y1.
  - Phase 2 emits pixel 2k = {Y0, Cb, Cr}.
  - Phase 3 emits pixel 2k+1 = {Y1, Cb, Cr}.
- Bytes after pixel ACTIVE_W-1 and before EAV are dropped. A single sync_err pulses per line for this overlength case.
- Bytes received while the detector is in G1/G2/XY are never emitted as pixels. FF and 00 are illegal in active data.
- Nothing is emitted while vblank=1 or hblank=1.
- Width rules: pix_x and pix_line wrap modulo 2^LINE_W. No saturation.

## Timing
- td_data is registered once at the input. All outputs are registered.
- A byte present on td_data at edge k that completes a pixel produces pix_valid, pix_*, and pix_x in the cycle after edge k+2 (2-clk latency).
- line_start, frame_start, hblank, field and vblank update with the same 2-clk latency relative to the XY byte. sync_err uses the same latency.
- line_start coincides with the cycle after the SAV's XY is processed. The first pix_valid of that line follows 3 cycles later.
- Reset values:
  - all pix_* = 0, pix_valid = 0, pix_x = 0, pix_line = 0
  - field = 0, vblank = 1, hblank = 1
  - strobes = 0, detector in SRCH
- Reset mid-line abandons the line. No pixels are emitted until the next valid SAV with V=0.

## Structure
- Shared package bt656_pkg:
  - TRS preamble constants (8'hFF, 8'h00)
  - XY bit positions
  - parity check function
  - byte-phase enum and detector state enum
- One sub-module: bt656_trs_detect. It contains the preamble FSM and XY parity check, and outputs code_vld, f, v, h, code_err.
- The top level holds the phase counter, chroma latches, counters and output registers.

## Test plan
- Field 0 stream of 2 blank lines then 3 active lines, with ACTIVE_W=8 and data Cb=10, Y=20+n, Cr=30:
  - 8 pix_valid per active line
  - pix_x = 0..7
  - pix_line = 0, 1, 2
  - frame_start exactly once, on the first active SAV
- XY=8'h80 (F0 V0 H0, parity 0000, valid SAV) -> accepted.
- XY=8'h81 (bad parity) -> sync_err pulse; hblank stays 1; no pixels.
- EAV after 5 pixels -> one sync_err pulse at EAV.
- 20 data bytes before EAV -> 8 pixels emitted, then one sync_err pulse.
- FF 00 FF 00 00 9D:
  - detector resyncs on the second FF
  - EAV (F0 V0 H1, 8'h9D) accepted
  - hblank=1
- rst asserted for 1 cycle in the middle of pixel 3:
  - all outputs reach their reset values on the next cycle
  - no pix_valid until the next SAV 80; the first pixel after that SAV has pix_x = 0
